// File: rtl/rv_data_memory.sv
// rv_data_memory: byte-addressable RISC-V data memory, 32-bit words, little-endian.
//
// Supports LB/LH/LW/LBU/LHU and SB/SH/SW selected by funct3. Loads have one cycle
// of latency and are marked by a read_valid pulse. A request that is misaligned,
// out of range or uses an illegal funct3 is dropped. Such a request produces an
// access_fault pulse on the next edge. After every reset the array is swept to
// zero, and ready stays low until the sweep is complete.
//
// State table:
//   state | meaning
//   INIT  | zeroing sweep, one word per edge; requests ignored, ready=0
//   RUN   | normal operation; requests decoded every edge, ready=1
//
// Ports:
//   clk           rising-edge clock
//   reset         asynchronous active-high reset
//   address       byte address
//   funct3        000 B, 001 H, 010 W, 100 BU, 101 HU
//   write_enable  store request this cycle
//   read_enable   load request this cycle
//   write_data    store data, right-justified
//   read_data     load result (held between loads)
//   read_valid    read_data updated by the load sampled on the previous edge
//   ready         sweep done, requests accepted
//   access_fault  request sampled on the previous edge was rejected
module rv_data_memory #(
    parameter int DEPTH_WORDS = 256,
    parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] address,
    input  logic [2:0]  funct3,
    input  logic        write_enable,
    input  logic        read_enable,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        read_valid,
    output logic        ready,
    output logic        access_fault
);

    typedef enum logic {INIT, RUN} state_t;

    state_t            state, state_nxt;
    logic [IDX_W-1:0]  init_ptr, init_ptr_nxt;

    logic [31:0]       mem [DEPTH_WORDS];

    logic [IDX_W-1:0]  idx;
    logic [1:0]        lane;
    logic              out_of_range, misaligned, ld_illegal, st_illegal, fault;
    logic              running, do_load, do_store, fault_now;
    logic [31:0]       rd_word, load_value, st_data;
    logic [7:0]        rd_byte;
    logic [15:0]       rd_half;
    logic [3:0]        st_be;

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= INIT;
            init_ptr <= '0;
        end else begin
            state    <= state_nxt;
            init_ptr <= init_ptr_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        init_ptr_nxt = init_ptr;
        case (state)
            INIT: begin
                init_ptr_nxt = init_ptr + 1'b1;
                if (init_ptr == IDX_W'(DEPTH_WORDS - 1)) begin
                    state_nxt = RUN;
                end
            end
            default: state_nxt = RUN;
        endcase
    end

    assign running = (state == RUN);
    assign ready   = running;

    // Request decode
    assign idx  = address[IDX_W+1:2];
    assign lane = address[1:0];

    // Any set bit above the word index means the address is out of range (no wrap).
    assign out_of_range = |address[31:IDX_W+2];
    assign misaligned   = ((funct3[1:0] == 2'b01) && address[0]) ||
                          ((funct3 == 3'b010) && (lane != 2'b00));
    assign ld_illegal   = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
    assign st_illegal   = funct3[2] || (funct3 == 3'b011);

    assign fault = (read_enable || write_enable) &&
                   (out_of_range || misaligned ||
                    (read_enable && ld_illegal) || (write_enable && st_illegal));

    assign do_load   = running && read_enable  && !fault;
    assign do_store  = running && write_enable && !fault;
    assign fault_now = running && fault;

    // Load path: the word is read before this edge's store, so a combined
    // request returns the pre-write contents.
    assign rd_word = mem[idx];

    always_comb begin
        rd_byte = rd_word[7:0];
        case (lane)
            2'd1:    rd_byte = rd_word[15:8];
            2'd2:    rd_byte = rd_word[23:16];
            2'd3:    rd_byte = rd_word[31:24];
            default: rd_byte = rd_word[7:0];
        endcase
    end

    assign rd_half = address[1] ? rd_word[31:16] : rd_word[15:0];

    always_comb begin
        load_value = rd_word;
        case (funct3)
            3'b000:  load_value = {{24{rd_byte[7]}}, rd_byte};
            3'b001:  load_value = {{16{rd_half[15]}}, rd_half};
            3'b100:  load_value = {24'h0, rd_byte};
            3'b101:  load_value = {16'h0, rd_half};
            default: load_value = rd_word;
        endcase
    end

    // Store path: replicate the data across lanes and select lanes with byte enables.
    always_comb begin
        st_data = write_data;
        st_be   = 4'b1111;
        case (funct3)
            3'b000: begin
                st_data = {4{write_data[7:0]}};
                st_be   = 4'b0001 << lane;
            end
            3'b001: begin
                st_data = {2{write_data[15:0]}};
                st_be   = address[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                st_data = write_data;
                st_be   = 4'b1111;
            end
        endcase
    end

    // The array has no reset; the INIT sweep clears it instead.
    always_ff @(posedge clk) begin
        if (state == INIT) begin
            mem[init_ptr] <= '0;
        end else if (do_store) begin
            for (int i = 0; i < 4; i++) begin
                if (st_be[i]) begin
                    mem[idx][8*i +: 8] <= st_data[8*i +: 8];
                end
            end
        end
    end

    // Registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            read_data    <= '0;
            read_valid   <= 1'b0;
            access_fault <= 1'b0;
        end else begin
            read_valid   <= do_load;
            access_fault <= fault_now;
            if (do_load) begin
                read_data <= load_value;
            end
        end
    end

endmodule

// File: tb/tb_rv_data_memory.sv
module tb_rv_data_memory;

    logic        clk;
    logic        reset;
    logic [31:0] address;
    logic [2:0]  funct3;
    logic        write_enable;
    logic        read_enable;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        read_valid;
    logic        ready;
    logic        access_fault;

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [2:0] F_B  = 3'b000;
    localparam logic [2:0] F_H  = 3'b001;
    localparam logic [2:0] F_W  = 3'b010;
    localparam logic [2:0] F_BU = 3'b100;
    localparam logic [2:0] F_HU = 3'b101;

    rv_data_memory #(.DEPTH_WORDS(256)) dut (
        .clk          (clk),
        .reset        (reset),
        .address      (address),
        .funct3       (funct3),
        .write_enable (write_enable),
        .read_enable  (read_enable),
        .write_data   (write_data),
        .read_data    (read_data),
        .read_valid   (read_valid),
        .ready        (ready),
        .access_fault (access_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Present one request, let it be sampled, and return #1 after the edge.
    task automatic access(input logic we, input logic re, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd);
        write_enable = we;
        read_enable  = re;
        funct3       = f3;
        address      = addr;
        write_data   = wd;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        access(1'b0, 1'b0, F_W, 32'h0, 32'h0);
    endtask

    task automatic load_chk(input string tag, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] exp);
        access(1'b0, 1'b1, f3, addr, 32'h0);
        chk({tag, "_data"}, read_data, exp);
        chk({tag, "_valid"}, {31'h0, read_valid}, 32'h1);
    endtask

    task automatic fault_chk(input string tag, input logic we, input logic re,
                             input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] held);
        access(we, re, f3, addr, 32'hFFFF_FFFF);
        chk({tag, "_fault"}, {31'h0, access_fault}, 32'h1);
        chk({tag, "_valid"}, {31'h0, read_valid}, 32'h0);
        chk({tag, "_held"}, read_data, held);
    endtask

    // Counts edges after reset release until ready rises (bounded).
    task automatic sweep_chk(input string tag);
        int n;
        n = 0;
        while (ready !== 1'b1 && n < 400) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({tag, "_edges"}, n, 256);
    endtask

    initial begin
        reset        = 1'b1;
        address      = '0;
        funct3       = F_W;
        write_enable = 1'b0;
        read_enable  = 1'b0;
        write_data   = '0;

        #6;
        chk("rst_rdata", read_data, 32'h0);
        chk("rst_valid", {31'h0, read_valid}, 32'h0);
        chk("rst_ready", {31'h0, ready}, 32'h0);
        chk("rst_fault", {31'h0, access_fault}, 32'h0);
        #2 reset = 1'b0;

        // Requests during the sweep must be ignored.
        write_enable = 1'b1;
        read_enable  = 1'b1;
        address      = 32'h0000_0010;
        write_data   = 32'h5A5A_5A5A;
        sweep_chk("sweep");
        write_enable = 1'b0;
        read_enable  = 1'b0;

        load_chk("lw_top", F_W, 32'h3FC, 32'h0);
        load_chk("lw_swept", F_W, 32'h10, 32'h0);

        access(1'b1, 1'b0, F_W, 32'h10, 32'hDEAD_BEEF);
        chk("sw_valid", {31'h0, read_valid}, 32'h0);
        chk("sw_fault", {31'h0, access_fault}, 32'h0);
        load_chk("lw10", F_W, 32'h10, 32'hDEAD_BEEF);
        load_chk("lb13", F_B, 32'h13, 32'hFFFF_FFDE);
        load_chk("lbu11", F_BU, 32'h11, 32'h0000_00BE);
        load_chk("lh12", F_H, 32'h12, 32'hFFFF_DEAD);
        load_chk("lhu10", F_HU, 32'h10, 32'h0000_BEEF);
        load_chk("lb10", F_B, 32'h10, 32'hFFFF_FFEF);
        load_chk("lhu12", F_HU, 32'h12, 32'h0000_DEAD);

        idle();
        chk("idle_valid", {31'h0, read_valid}, 32'h0);
        chk("idle_fault", {31'h0, access_fault}, 32'h0);
        chk("idle_held", read_data, 32'h0000_DEAD);

        access(1'b1, 1'b0, F_W, 32'h20, 32'h0);
        access(1'b1, 1'b0, F_B, 32'h21, 32'hABCD_EFFF);
        access(1'b1, 1'b0, F_H, 32'h22, 32'h5555_1234);
        load_chk("partial", F_W, 32'h20, 32'h1234_FF00);

        access(1'b1, 1'b0, F_W, 32'h04, 32'hCAFE_F00D);
        fault_chk("lw06", 1'b0, 1'b1, F_W, 32'h06, 32'h1234_FF00);
        fault_chk("sh05", 1'b1, 1'b0, F_H, 32'h05, 32'h1234_FF00);
        fault_chk("lb400", 1'b0, 1'b1, F_B, 32'h400, 32'h1234_FF00);
        fault_chk("f3_011", 1'b0, 1'b1, 3'b011, 32'h04, 32'h1234_FF00);
        fault_chk("sw06", 1'b1, 1'b0, F_W, 32'h06, 32'h1234_FF00);
        fault_chk("sbu", 1'b1, 1'b0, F_BU, 32'h04, 32'h1234_FF00);
        fault_chk("sw400", 1'b1, 1'b0, F_W, 32'h400, 32'h1234_FF00);
        fault_chk("rw_bu", 1'b1, 1'b1, F_BU, 32'h04, 32'h1234_FF00);
        idle();
        chk("fault_pulse", {31'h0, access_fault}, 32'h0);
        load_chk("lw04", F_W, 32'h04, 32'hCAFE_F00D);
        load_chk("nowrap", F_W, 32'h00, 32'h0);

        access(1'b1, 1'b0, F_W, 32'h08, 32'h1111_1111);
        access(1'b1, 1'b1, F_W, 32'h08, 32'h2222_2222);
        chk("rw_old", read_data, 32'h1111_1111);
        chk("rw_valid", {31'h0, read_valid}, 32'h1);
        chk("rw_fault", {31'h0, access_fault}, 32'h0);
        load_chk("rw_new", F_W, 32'h08, 32'h2222_2222);

        // Reset mid-load: outputs must clear without a clock edge.
        load_chk("pre_rst", F_W, 32'h10, 32'hDEAD_BEEF);
        #1 reset = 1'b1;
        #1;
        chk("mid_rst_rdata", read_data, 32'h0);
        chk("mid_rst_valid", {31'h0, read_valid}, 32'h0);
        chk("mid_rst_ready", {31'h0, ready}, 32'h0);
        #1 reset = 1'b0;
        read_enable = 1'b0;
        sweep_chk("resweep");
        load_chk("cleared10", F_W, 32'h10, 32'h0);
        load_chk("cleared08", F_W, 32'h08, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/rv_data_memory.md
Name: rv_data_memory

Overview:
Parametrised, byte-addressable RISC-V data memory that replaces the 8-bit single-lane data memory. It supports 32-bit words and RISC-V load/store sizes (B/H/W, signed and unsigned loads) through funct3. It has a registered read path with a valid strobe, and detects misaligned, out-of-range and illegal accesses. After every reset it runs a self-clearing sweep and holds ready low until the memory is zeroed. It sits between the execute stage and writeback.

Parameters:
DEPTH_WORDS, 256, number of 32-bit words; power of two, minimum 4.
IDX_W, $clog2(DEPTH_WORDS), word-index width (derived; do not override).

Ports:
clk  input  1  rising-edge clock.
reset  input  1  asynchronous, active-high reset.
address  input  32  byte address.
funct3  input  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
write_enable  input  1  store request this cycle.
read_enable  input  1  load request this cycle.
write_data  input  32  store data, right-justified (SB uses [7:0], SH uses [15:0]).
read_data  output  32  load result, sign- or zero-extended; holds its value between loads.
read_valid  output  1  1-cycle pulse: read_data updated by the load sampled on the previous edge.
ready  output  1  1 when the sweep is done and requests are accepted.
access_fault  output  1  1-cycle pulse: the request sampled on the previous edge was rejected.

Behaviour:
- One clock domain. Reset is asynchronous and active-high.
- Reset asserted, at any time including mid-access or mid-sweep:
  - state=INIT, init_ptr=0.
  - read_data=0, read_valid=0, ready=0, access_fault=0.
  - Any in-flight request is discarded.
- INIT state:
  - Each edge writes 0 to mem[init_ptr] and increments init_ptr.
  - When init_ptr==DEPTH_WORDS-1 is written, go to RUN. ready=1 from that edge.
  - The first RUN edge is DEPTH_WORDS edges after reset deasserts.
  - Requests during INIT are ignored: no write, no read_valid, no fault.
- RUN state, per-edge request decode:
  - Word index = address[IDX_W+1:2]. Byte lane = address[1:0].
  - Out-of-range: address >= 4*DEPTH_WORDS. No wrap-around.
  - Misaligned: H/HU with address[0]=1, or W with address[1:0]!=0.
  - Illegal funct3:
    - Loads: anything other than 000, 001, 010, 100, 101.
    - Stores: anything other than 000, 001, 010.
  - Any of these three on an enabled request:
    - Memory unchanged, read_data unchanged, read_valid=0.
    - access_fault=1 on the next edge.
- Store (legal):
  - SB writes byte lane a[1:0].
  - SH writes lanes {a[1],0} and {a[1],1}.
  - SW writes all four lanes.
  - Little-endian; other lanes untouched.
  - Memory is updated at the sampling edge.
- Load (legal):
  - Latency 1: read_data and read_valid=1 are registered on the sampling edge.
  - Byte/half is extracted from the lane, then sign-extended (B/H) or zero-extended (BU/HU).
- Simultaneous read_enable and write_enable:
  - Both are performed at the same address and size.
  - read_data returns the pre-write contents (read-before-write).
  - If the request faults, neither is performed and there is a single access_fault pulse.
- Back-to-back loads: one result per cycle. read_valid stays high while legal loads continue each cycle.
- Neither enable: read_valid=0, access_fault=0, read_data holds.

Test Plan:
- Reset sweep: pulse reset for 8 time units with DEPTH_WORDS=256. ready stays 0 for exactly 256 edges then rises. LW at 0x3FC then returns 0x00000000 with read_valid=1 one cycle later.
- SW 0xDEADBEEF at 0x10. Then:
  - LW 0x10 -> 0xDEADBEEF.
  - LB 0x13 -> 0xFFFFFFDE.
  - LBU 0x11 -> 0x000000BE.
  - LH 0x12 -> 0xFFFFDEAD.
  - LHU 0x10 -> 0x0000BEEF.
- Partial stores: SW 0 at 0x20, SB 0xFF at 0x21, SH 0x1234 at 0x22. LW 0x20 -> 0x1234FF00.
- Faults:
  - LW at 0x06, SH at 0x05, LB at 0x400 (DEPTH 256): each gives access_fault=1 one cycle later, read_valid=0, read_data unchanged.
  - funct3=011: access_fault=1.
  - A following LW 0x04 returns the prior contents.
- Simultaneous access: mem[0x08]=0x11111111. Same-cycle SW 0x22222222 and LW 0x08 -> read_data 0x11111111. The next LW returns 0x22222222.
- Reset mid-operation:
  - Assert reset during a load cycle: read_valid and read_data go to 0 immediately, without waiting for a clock edge.
  - After release, ready=0 for 256 edges and previously stored data reads back 0.
